pipe_stage_buf: RTL and testbench
=================================

Name: pipe_stage_buf

Overview:
- Parametrised inter-stage pipeline register that replaces the fixed-field stage buffers (fetch/decode, decode/ALU, ALU/mem, mem/WB).
- Carries a control bundle and a data bundle across one stage boundary.
- Adds a valid/ready handshake, an optional 2-entry skid buffer for back-pressure, flush with bubble insertion, and a saturating stall counter for performance debug.

Parameters:
- CTRL_W, 13, width of control bundle (WB+Mem+Ex+chg_flag); zeroed on bubble/flush.
- DATA_W, 89, width of data bundle (pc, register ids, immediate, read data); held, never zeroed except at reset.
- SKID, 1, 1 = 2-entry skid buffer with registered in_ready; 0 = single register with combinational in_ready.
- CNT_W, 16, stall counter width.

Ports:
- clk, in, 1, stage clock; all state updates on the falling edge, matching the existing pipeline buffers.
- rst, in, 1, synchronous active-low reset, sampled on the falling edge of clk.
- flush, in, 1, kill contents and insert bubble.
- in_valid, in, 1, upstream entry present.
- in_ready, out, 1, buffer accepts the entry this cycle.
- in_ctrl, in, CTRL_W, control bundle.
- in_data, in, DATA_W, data bundle.
- out_valid, out, 1, output entry valid.
- out_ready, in, 1, downstream consumes the entry this cycle.
- out_ctrl, out, CTRL_W, registered control; 0 whenever out_valid=0.
- out_data, out, DATA_W, registered data.
- cnt_clr, in, 1, clear stall counter.
- stall_cnt, out, CNT_W, saturating count of back-pressured cycles.

Behaviour:
- Reset (rst=0 at a falling edge):
  - state EMPTY; out_valid=0, out_ctrl=0, out_data=0.
  - skid contents=0; stall_cnt=0.
  - in_ready=1 from the next cycle (SKID=1).
  - Reset overrides flush and handshake. Reset mid-transfer silently discards in-flight entries.
- Definitions: accept = in_valid & in_ready; consume = out_valid & out_ready.
- States (SKID=1): EMPTY (no entry), ONE (main register holds an entry), TWO (main and skid both hold entries). Transitions per falling edge:
  - EMPTY: accept -> main<=in, ONE. Otherwise stay.
  - ONE, consume & accept: main<=in, stay ONE.
  - ONE, consume & !accept: -> EMPTY, out_ctrl<=0.
  - ONE, !consume & accept: skid<=in, -> TWO.
  - ONE, otherwise: hold.
  - TWO: in_ready=0. Consume -> main<=skid, -> ONE. Otherwise hold.
- in_ready (SKID=1) = (state != TWO); driven from a register, with no combinational path from out_ready.
- SKID=0:
  - No TWO state and no skid register.
  - in_ready = !out_valid | out_ready (combinational).
  - Transitions are as for SKID=1 with TWO unreachable.
- Latency: an accepted entry appears at out_* one falling edge later when the buffer is EMPTY or ONE with a simultaneous consume. An entry parked in the skid register appears on the edge after it is consumed from main.
- Ordering is strict FIFO. No entry is duplicated or dropped except by flush or reset.
- Flush:
  - Takes priority over the handshake: state<=EMPTY, out_valid<=0, out_ctrl<=0; out_data and skid data held.
  - An input presented with flush is dropped.
  - A consume in the flush cycle is still counted as taken by downstream.
- out_ctrl is forced to 0 on every transition into EMPTY, so downstream decodes a NOP bubble.
- stall_cnt:
  - Increments on each falling edge where out_valid & !out_ready.
  - Saturates at 2^CNT_W-1; does not wrap.
  - cnt_clr sets it to 0 and has priority over increment.
  - Flush does not affect stall_cnt.
- No X on any output after reset. Data bits pass through unmodified; no width conversion.

Decomposition:
- Shared package pipe_pkg:
  - state encoding typedef (EMPTY=2'b00, ONE=2'b01, TWO=2'b10).
  - per-stage CTRL_W/DATA_W constants derived from the WB/Mem/Ex field widths (4/6/3) plus chg_flag.
- One natural sub-module: sat_counter (CNT_W, inc, clr, synchronous active-low rst), reused by the other stage buffers' debug counters.

Test Plan:
- Reset: hold rst=0 for 2 edges with in_valid=1, in_ctrl=13'h1FFF -> out_valid=0, out_ctrl=0, out_data=0, stall_cnt=0, in_ready=1 after release.
- Streaming: SKID=1, out_ready=1, send 8 entries data=0..7 back-to-back -> out_data 0..7 on consecutive edges, 1-edge latency, in_ready stays 1, stall_cnt=0.
- Back-pressure: send A=0x11, B=0x22 with out_ready=0:
  - state TWO, in_ready=0, C=0x33 held upstream.
  - raise out_ready -> outputs A, B, C in order, no loss.
  - stall_cnt = number of stalled edges.
- Flush: state TWO, assert flush with in_valid=1 (D=0x44) -> next edge out_valid=0, out_ctrl=0, in_ready=1, D never appears.
- Counter saturation: CNT_W=4, out_ready=0 for 20 edges -> stall_cnt=15. Then cnt_clr with stall active -> 0, then increments from 1.
- SKID=0: out_ready toggles 1,0,1 under continuous in_valid -> in_ready follows !out_valid | out_ready the same cycle, order preserved, no entry duplicated.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared definitions for the inter-stage pipeline buffers: buffer state
// encoding and the default control/data bundle widths.
package pipe_pkg;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'b00,
        ST_ONE   = 2'b01,
        ST_TWO   = 2'b10
    } buf_state_e;

    // The chg_flag travels as the top bit of the 3-bit Ex field.
    localparam int WB_W       = 4;
    localparam int MEM_W      = 6;
    localparam int EX_W       = 3;
    localparam int CTRL_W_DEF = WB_W + MEM_W + EX_W;
    localparam int DATA_W_DEF = 89;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with clear priority; updates on the falling edge,
// synchronous active-low reset.
module sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    input  logic             clr,
    output logic [CNT_W-1:0] cnt
);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(negedge clk) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/pipe_stage_buf.sv
// Inter-stage pipeline register with valid/ready handshake, optional 2-entry
// skid buffer, flush-to-bubble and a saturating back-pressure counter.
module pipe_stage_buf
    import pipe_pkg::*;
#(
    parameter int CTRL_W = CTRL_W_DEF,
    parameter int DATA_W = DATA_W_DEF,
    parameter int SKID   = 1,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data,
    input  logic              cnt_clr,
    output logic [CNT_W-1:0]  stall_cnt
);

    buf_state_e        state_q, state_d;
    logic [CTRL_W-1:0] main_ctrl_q, main_ctrl_d;
    logic [DATA_W-1:0] main_data_q, main_data_d;
    logic [CTRL_W-1:0] skid_ctrl_q, skid_ctrl_d;
    logic [DATA_W-1:0] skid_data_q, skid_data_d;
    logic              accept;
    logic              consume;

    assign out_valid = (state_q != ST_EMPTY);
    assign out_ctrl  = main_ctrl_q;
    assign out_data  = main_data_q;
    assign accept    = in_valid & in_ready;
    assign consume   = out_valid & out_ready;

    // NOTE: every next-state signal takes its hold value first, so no path
    // through this block leaves a signal unassigned and no latch is inferred.
    always_comb begin
        state_d     = state_q;
        main_ctrl_d = main_ctrl_q;
        main_data_d = main_data_q;
        skid_ctrl_d = skid_ctrl_q;
        skid_data_d = skid_data_q;

        if (flush) begin
            state_d     = ST_EMPTY;
            main_ctrl_d = '0;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (accept) begin
                        main_ctrl_d = in_ctrl;
                        main_data_d = in_data;
                        state_d     = ST_ONE;
                    end
                end
                ST_ONE: begin
                    if (consume && accept) begin
                        main_ctrl_d = in_ctrl;
                        main_data_d = in_data;
                    end else if (consume) begin
                        main_ctrl_d = '0;
                        state_d     = ST_EMPTY;
                    end else if (accept && (SKID != 0)) begin
                        skid_ctrl_d = in_ctrl;
                        skid_data_d = in_data;
                        state_d     = ST_TWO;
                    end
                end
                ST_TWO: begin
                    if (consume) begin
                        main_ctrl_d = skid_ctrl_q;
                        main_data_d = skid_data_q;
                        state_d     = ST_ONE;
                    end
                end
                default: begin
                    main_ctrl_d = '0;
                    state_d     = ST_EMPTY;
                end
            endcase
        end
    end

    // NOTE: the payload registers are reset along with the state so that
    // out_data never shows X, even though it is qualified by out_valid.
    always_ff @(negedge clk) begin
        if (!rst) begin
            state_q     <= ST_EMPTY;
            main_ctrl_q <= '0;
            main_data_q <= '0;
        end else begin
            // NOTE: non-blocking assignments keep all registers sampling the
            // same pre-edge values regardless of statement order.
            state_q     <= state_d;
            main_ctrl_q <= main_ctrl_d;
            main_data_q <= main_data_d;
        end
    end

    generate
        if (SKID != 0) begin : g_skid
            logic in_ready_q;

            always_ff @(negedge clk) begin
                if (!rst) begin
                    skid_ctrl_q <= '0;
                    skid_data_q <= '0;
                    in_ready_q  <= 1'b1;
                end else begin
                    skid_ctrl_q <= skid_ctrl_d;
                    skid_data_q <= skid_data_d;
                    in_ready_q  <= (state_d != ST_TWO);
                end
            end

            // Registered ready breaks the out_ready -> in_ready timing path.
            assign in_ready = in_ready_q;
        end else begin : g_noskid
            assign skid_ctrl_q = '0;
            assign skid_data_q = '0;
            assign in_ready    = !out_valid | out_ready;
        end
    endgenerate

    sat_counter #(
        .CNT_W (CNT_W)
    ) u_stall_cnt (
        .clk (clk),
        .rst (rst),
        .inc (out_valid & ~out_ready),
        .clr (cnt_clr),
        .cnt (stall_cnt)
    );

endmodule

// File: tb/tb_pipe_stage_buf.sv
// Directed bench for pipe_stage_buf: default skid build, a 4-bit counter
// build and a no-skid build, all driven from the same stimulus.
module tb_pipe_stage_buf;

    localparam int CW = 13;
    localparam int DW = 89;

    logic          clk;
    logic          rst;
    logic          flush;
    logic          in_valid;
    logic [CW-1:0] in_ctrl;
    logic [DW-1:0] in_data;
    logic          out_ready;
    logic          cnt_clr;

    logic          a_in_ready, a_out_valid;
    logic [CW-1:0] a_out_ctrl;
    logic [DW-1:0] a_out_data;
    logic [15:0]   a_stall;

    logic          s_in_ready, s_out_valid;
    logic [CW-1:0] s_out_ctrl;
    logic [DW-1:0] s_out_data;
    logic [3:0]    s_stall;

    logic          n_in_ready, n_out_valid;
    logic [CW-1:0] n_out_ctrl;
    logic [DW-1:0] n_out_data;
    logic [15:0]   n_stall;

    int n_total = 0;
    int n_pass  = 0;

    pipe_stage_buf #(.CTRL_W(CW), .DATA_W(DW), .SKID(1), .CNT_W(16)) u_dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(a_in_ready), .in_ctrl(in_ctrl), .in_data(in_data),
        .out_valid(a_out_valid), .out_ready(out_ready), .out_ctrl(a_out_ctrl), .out_data(a_out_data),
        .cnt_clr(cnt_clr), .stall_cnt(a_stall)
    );

    pipe_stage_buf #(.CTRL_W(CW), .DATA_W(DW), .SKID(1), .CNT_W(4)) u_sat (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(s_in_ready), .in_ctrl(in_ctrl), .in_data(in_data),
        .out_valid(s_out_valid), .out_ready(out_ready), .out_ctrl(s_out_ctrl), .out_data(s_out_data),
        .cnt_clr(cnt_clr), .stall_cnt(s_stall)
    );

    pipe_stage_buf #(.CTRL_W(CW), .DATA_W(DW), .SKID(0), .CNT_W(16)) u_noskid (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(n_in_ready), .in_ctrl(in_ctrl), .in_data(in_data),
        .out_valid(n_out_valid), .out_ready(out_ready), .out_ctrl(n_out_ctrl), .out_data(n_out_data),
        .cnt_clr(cnt_clr), .stall_cnt(n_stall)
    );

    initial begin
        clk = 1'b1;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Outputs settle on the falling edge; sample and re-drive 1 time unit later.
    task automatic step();
        @(negedge clk);
        #1;
    endtask

    function automatic logic [CW-1:0] ctrl_of(input logic [DW-1:0] d);
        return 13'h1000 | d[12:0];
    endfunction

    task automatic drive(input logic v, input logic [DW-1:0] d);
        in_valid = v;
        in_data  = d;
        in_ctrl  = ctrl_of(d);
    endtask

    initial begin
        rst       = 1'b0;
        flush     = 1'b0;
        cnt_clr   = 1'b0;
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_ctrl   = 13'h1FFF;
        in_data   = '1;
        #1;

        // Reset with a valid input pending.
        step();
        step();
        check("rst_out_valid", 128'(a_out_valid), 128'(0));
        check("rst_out_ctrl",  128'(a_out_ctrl),  128'(0));
        check("rst_out_data",  128'(a_out_data),  128'(0));
        check("rst_stall",     128'(a_stall),     128'(0));
        rst = 1'b1;
        drive(1'b0, '0);
        step();
        check("rst_in_ready",  128'(a_in_ready),  128'(1));
        check("rst_idle_valid", 128'(a_out_valid), 128'(0));

        // Streaming with downstream always ready.
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, DW'(i));
            step();
            check("stream_data",  128'(a_out_data),  128'(i));
            check("stream_ctrl",  128'(a_out_ctrl),  128'(ctrl_of(DW'(i))));
            check("stream_ready", 128'(a_in_ready),  128'(1));
        end
        check("stream_stall", 128'(a_stall), 128'(0));
        drive(1'b0, '0);
        step();
        check("stream_drain_valid", 128'(a_out_valid), 128'(0));
        check("stream_drain_ctrl",  128'(a_out_ctrl),  128'(0));

        // Back-pressure fills main then skid; C waits upstream.
        out_ready = 1'b0;
        drive(1'b1, DW'(8'h11));
        step();
        check("bp_a_out", 128'(a_out_data), 128'(8'h11));
        drive(1'b1, DW'(8'h22));
        step();
        check("bp_two_ready", 128'(a_in_ready), 128'(0));
        check("bp_two_out",   128'(a_out_data), 128'(8'h11));
        drive(1'b1, DW'(8'h33));
        step();
        check("bp_hold_ready", 128'(a_in_ready), 128'(0));
        check("bp_hold_out",   128'(a_out_data), 128'(8'h11));
        check("bp_stall2",     128'(a_stall),    128'(2));
        out_ready = 1'b1;
        step();
        check("bp_b_out",   128'(a_out_data), 128'(8'h22));
        check("bp_b_ctrl",  128'(a_out_ctrl), 128'(ctrl_of(DW'(8'h22))));
        check("bp_b_ready", 128'(a_in_ready), 128'(1));
        step();
        check("bp_c_out", 128'(a_out_data), 128'(8'h33));
        drive(1'b0, '0);
        step();
        check("bp_end_valid", 128'(a_out_valid), 128'(0));
        check("bp_end_ctrl",  128'(a_out_ctrl),  128'(0));
        check("bp_end_data",  128'(a_out_data),  128'(8'h33));
        check("bp_end_stall", 128'(a_stall),     128'(2));

        // Flush while TWO, with D presented in the flush cycle.
        out_ready = 1'b0;
        drive(1'b1, DW'(8'h55));
        step();
        drive(1'b1, DW'(8'h66));
        step();
        check("fl_pre_ready", 128'(a_in_ready), 128'(0));
        flush = 1'b1;
        drive(1'b1, DW'(8'h44));
        step();
        flush = 1'b0;
        drive(1'b0, '0);
        check("fl_valid", 128'(a_out_valid), 128'(0));
        check("fl_ctrl",  128'(a_out_ctrl),  128'(0));
        check("fl_ready", 128'(a_in_ready),  128'(1));
        check("fl_data",  128'(a_out_data),  128'(8'h55));
        check("fl_stall", 128'(a_stall),     128'(4));
        out_ready = 1'b1;
        step();
        check("fl_no_d", 128'(a_out_valid), 128'(0));
        drive(1'b1, DW'(8'h77));
        step();
        check("fl_next_data",  128'(a_out_data),  128'(8'h77));
        check("fl_next_valid", 128'(a_out_valid), 128'(1));
        drive(1'b0, '0);
        step();
        check("fl_no_stale", 128'(a_out_valid), 128'(0));

        // Counter saturation on the 4-bit build, then clear under stall.
        out_ready = 1'b0;
        cnt_clr   = 1'b1;
        drive(1'b1, DW'(8'h88));
        step();
        cnt_clr = 1'b0;
        drive(1'b0, '0);
        check("sat_clr0", 128'(s_stall), 128'(0));
        for (int i = 0; i < 15; i++) step();
        check("sat_at15", 128'(s_stall), 128'(15));
        for (int i = 0; i < 5; i++) step();
        check("sat_hold15", 128'(s_stall), 128'(15));
        check("sat_wide20", 128'(a_stall), 128'(20));
        cnt_clr = 1'b1;
        step();
        check("sat_clr_prio", 128'(s_stall), 128'(0));
        cnt_clr = 1'b0;
        step();
        check("sat_restart",  128'(s_stall), 128'(1));
        check("sat_restart_w", 128'(a_stall), 128'(1));
        out_ready = 1'b1;
        step();
        check("sat_drain", 128'(a_out_valid), 128'(0));

        // No-skid build: combinational in_ready, out_ready pattern 1,1,0,1.
        drive(1'b1, DW'(8'hA0));
        #1;
        check("ns_ready_empty", 128'(n_in_ready), 128'(1));
        step();
        check("ns_a0", 128'(n_out_data), 128'(8'hA0));
        check("ns_a0_valid", 128'(n_out_valid), 128'(1));
        drive(1'b1, DW'(8'hA1));
        #1;
        check("ns_ready_or1", 128'(n_in_ready), 128'(1));
        step();
        check("ns_a1", 128'(n_out_data), 128'(8'hA1));
        out_ready = 1'b0;
        drive(1'b1, DW'(8'hA2));
        #1;
        check("ns_ready_or0", 128'(n_in_ready), 128'(0));
        step();
        check("ns_a1_hold", 128'(n_out_data), 128'(8'hA1));
        check("ns_a1_ctrl", 128'(n_out_ctrl), 128'(ctrl_of(DW'(8'hA1))));
        out_ready = 1'b1;
        #1;
        check("ns_ready_back", 128'(n_in_ready), 128'(1));
        step();
        check("ns_a2", 128'(n_out_data), 128'(8'hA2));
        drive(1'b0, '0);
        step();
        check("ns_end_valid", 128'(n_out_valid), 128'(0));
        check("ns_end_ctrl",  128'(n_out_ctrl),  128'(0));

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
